// File: rtl/rr_bus_arbiter4.sv
// ----------------------------------------------------------------------------
// rr_bus_arbiter4
//   Round-robin arbiter that shares one bus/memory port among four masters.
//   An owner keeps the port until it drops its request. On release the port
//   passes straight to the next pending requester in rotating order, with no
//   dead cycle in between. grant, sel and busy are all registered.
//
//   Optional feature (compile-time macro RR_ARB_HOLD_LIMIT_EN):
//     When defined, an owner that has held the port for MAX_HOLD consecutive
//     cycles is preempted if any other master is waiting. The preempted
//     master stays pending and competes normally. When undefined, the hold
//     counter is removed and MAX_HOLD is only range-checked.
//
// Parameters
//   MAX_HOLD : owned cycles before forced handover (1..255)
//
// Ports
//   clk   in   system clock, rising edge
//   reset in   synchronous, active-high reset
//   req   in   [3:0] per-master request, held for the whole transaction
//   grant out  [3:0] registered one-hot grant, zero when idle
//   sel   out  [1:0] index of current/last owner (port mux select)
//   busy  out  high whenever any grant bit is high
// ----------------------------------------------------------------------------
module rr_bus_arbiter4 #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic [1:0] sel,
    output logic       busy
);

    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_hold
        $error("rr_bus_arbiter4: MAX_HOLD must be 1..255");
    end

    typedef enum logic {IDLE, OWN} state_t;

    state_t     state;
    logic [1:0] last;     // last winner; search starts one past it

    // Returns {found, index} of the first set bit of r, scanning
    // after+1, after+2, ... wrapping 3->0. Scanning from far to near lets
    // the nearest hit overwrite the others, so no early exit is needed.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] after);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 4; k >= 1; k--) begin
            idx = after + 2'(k);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    logic [2:0] pick_idle;   // winner when no one owns the port
    logic [2:0] pick_other;  // winner among everyone except the owner
    logic       preempt;
    logic       take_over;

    assign pick_idle  = rr_pick(req, last);
    // Masking the owner also keeps a preempted owner from winning itself.
    assign pick_other = rr_pick(req & ~(4'b0001 << sel), sel);

`ifdef RR_ARB_HOLD_LIMIT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
    logic [7:0] hold_cnt;    // owned cycles minus one, saturating

    assign preempt = (hold_cnt >= HOLD_LAST);
`else
    assign preempt = 1'b0;
`endif

    // Owner gives up the port this edge: voluntary release, or a hold-limit
    // preemption that only counts when somebody else is actually waiting.
    assign take_over = (state == OWN) && (!req[sel] || (preempt && pick_other[2]));

`ifdef RR_ARB_HOLD_LIMIT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_cnt <= 8'd0;
        end else if (state == OWN && !take_over) begin
            if (hold_cnt != 8'hFF) hold_cnt <= hold_cnt + 8'd1;
        end else begin
            hold_cnt <= 8'd0;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            grant <= 4'b0000;
            sel   <= 2'b00;
            busy  <= 1'b0;
            last  <= 2'd3;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_idle[2]) begin
                        state <= OWN;
                        grant <= 4'b0001 << pick_idle[1:0];
                        sel   <= pick_idle[1:0];
                        last  <= pick_idle[1:0];
                        busy  <= 1'b1;
                    end
                end
                OWN: begin
                    if (take_over) begin
                        if (pick_other[2]) begin
                            grant <= 4'b0001 << pick_other[1:0];
                            sel   <= pick_other[1:0];
                            last  <= pick_other[1:0];
                        end else begin
                            // sel holds the last owner so the port mux stays put
                            state <= IDLE;
                            grant <= 4'b0000;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_bus_arbiter4.sv
module tb_rr_bus_arbiter4;

    localparam int MAX_HOLD = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       busy;

    int tests = 0;
    int fails = 0;

    rr_bus_arbiter4 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk  (clk),
        .reset(reset),
        .req  (req),
        .grant(grant),
        .sel  (sel),
        .busy (busy)
    );

    always #5 clk = ~clk;

`ifdef RR_ARB_HOLD_LIMIT_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: who owns the port, how long they have owned it,
    // and who won last. Rotation is a plain scan over (last+k) mod 4.
    // ------------------------------------------------------------------
    int m_owner = -1;   // -1 = nobody
    int m_last  = 3;
    int m_sel   = 0;
    int m_owned = 0;    // cycles the current owner has held the grant

    function automatic int next_after(input logic [3:0] r, input int after);
        for (int k = 1; k <= 4; k++) begin
            if (r[(after + k) % 4]) return (after + k) % 4;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        logic [3:0] r;
        logic [3:0] others;
        int w;
        r = req;
        if (reset) begin
            m_owner = -1; m_last = 3; m_sel = 0; m_owned = 0;
        end else if (m_owner < 0) begin
            w = next_after(r, m_last);
            if (w >= 0) begin
                m_owner = w; m_last = w; m_sel = w; m_owned = 1;
            end
        end else begin
            others = r & ~(4'b0001 << m_owner);
            if (!r[m_owner] || (HOLD_EN && m_owned >= MAX_HOLD && others != 0)) begin
                w = next_after(others, m_owner);
                if (w >= 0) begin
                    m_owner = w; m_last = w; m_sel = w; m_owned = 1;
                end else begin
                    m_owner = -1;
                end
            end else begin
                m_owned++;
            end
        end
        #1;
        chk("model_grant", grant, (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
        chk("model_sel", sel, m_sel);
        chk("inv_busy", busy, |grant);
        if (grant != 0) chk("inv_onehot_sel", grant, 4'b0001 << sel);
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic expect_out(input string name, input logic [3:0] g, input logic [1:0] s, input logic b);
        chk({name, "_grant"}, grant, g);
        chk({name, "_sel"}, sel, s);
        chk({name, "_busy"}, busy, b);
    endtask

    initial begin
        reset = 1'b1;
        req   = 4'b0000;
        step();
        step();
        reset = 1'b0;
        expect_out("reset", 4'b0000, 2'b00, 1'b0);

        // idle with no requests
        for (int i = 0; i < 3; i++) begin
            step();
            expect_out("idle", 4'b0000, 2'b00, 1'b0);
        end

        // 1010 from reset: master 1 first, then handover to 3 with no gap
        req = 4'b1010;
        step();
        expect_out("first", 4'b0010, 2'b01, 1'b1);
        step();
        step();
        expect_out("hold1", 4'b0010, 2'b01, 1'b1);
        req = 4'b1000;
        step();
        expect_out("handover", 4'b1000, 2'b11, 1'b1);
        req = 4'b0000;
        step();
        expect_out("release3", 4'b0000, 2'b11, 1'b0);

        // fairness: everyone requests, owner drops for one cycle
        req = 4'b1111;
        step();
        expect_out("fair0", 4'b0001, 2'b00, 1'b1);
        for (int i = 1; i < 8; i++) begin
            req = 4'b1111 & ~grant;
            step();
            chk("fair_seq", grant, 4'b0001 << (i % 4));
        end
        req = 4'b0000;
        step();
        expect_out("fair_end", 4'b0000, 2'b11, 1'b0);

        // sole owner 2 releases; sel must stay 10 while idle
        req = 4'b0100;
        step();
        expect_out("own2", 4'b0100, 2'b10, 1'b1);
        step();
        req = 4'b0000;
        step();
        expect_out("idle2", 4'b0000, 2'b10, 1'b0);
        step();
        expect_out("idle2b", 4'b0000, 2'b10, 1'b0);
        req = 4'b0100;
        step();
        expect_out("regrant2", 4'b0100, 2'b10, 1'b1);

        // reset mid-ownership, then master 0 wins from 1111
        reset = 1'b1;
        step();
        expect_out("midreset", 4'b0000, 2'b00, 1'b0);
        reset = 1'b0;
        req   = 4'b1111;
        step();
        expect_out("post_reset", 4'b0001, 2'b00, 1'b1);
        req = 4'b0000;
        step();

        // hold limit: master 0 never lets go, master 3 arrives in cycle 2
        req = 4'b0001;
        step();
        expect_out("hog1", 4'b0001, 2'b00, 1'b1);
        step();
        req = 4'b1001;
        step();
        chk("hog3", grant, 4'b0001);
        step();
        chk("hog4", grant, 4'b0001);
`ifdef RR_ARB_HOLD_LIMIT_EN
        step();
        expect_out("preempt", 4'b1000, 2'b11, 1'b1);
`else
        for (int i = 0; i < 20; i++) begin
            step();
            chk("no_preempt", grant, 4'b0001);
        end
`endif
        req = 4'b0000;
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
